// File: rtl/truth_table_checker_pkg.sv
// truth_table_checker_pkg: shared FSM state type and timer width helper
package truth_table_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    // Settle counter must hold SETTLE-1; one spare bit keeps SETTLE=1 at width 1.
    function automatic int timer_w(input int settle);
        return $clog2(settle) + 1;
    endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: stimulus/response and result bundle of the checker
//   master: controller side (drives start/expected/dut_out, reads results)
//   slave : checker side (drives dut_in and results)
interface truth_table_checker_if #(
    parameter int N_IN = 4
);
    localparam int CODES = 1 << N_IN;

    logic             start;
    logic [CODES-1:0] expected;
    logic [N_IN-1:0]  dut_in;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_IN:0]    err_count;
    logic [N_IN-1:0]  first_err;
    logic [CODES-1:0] captured;

    modport master (
        output start, expected, dut_out,
        input  dut_in, busy, done, pass, err_count, first_err, captured
    );

    modport slave (
        input  start, expected, dut_out,
        output dut_in, busy, done, pass, err_count, first_err, captured
    );

endinterface

// File: rtl/truth_table_checker_settle_timer.sv
// settle_timer: loadable down-counter giving SETTLE-1 wait cycles per code
//   clk, rst : clock, synchronous active-high reset
//   load_i   : reload with SETTLE-1
//   dec_i    : decrement (stops at zero)
//   zero_o   : counter is zero
module settle_timer
    import truth_table_checker_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);
    localparam int TW = timer_w(SETTLE);

    logic [TW-1:0] cnt_q, cnt_d;

    assign zero_o = cnt_q == '0;

    always_comb begin
        cnt_d = load_i ? TW'(SETTLE - 1) : (dec_i && !zero_o) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: exhaustive sweep of a combinational DUT against an expected truth table
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of truth_table_checker_if (start/expected/dut_out in,
//              dut_in/busy/done/pass/err_count/first_err/captured out)
module truth_table_checker
    import truth_table_checker_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_checker_if.slave  bus
);
    localparam int CODES = 1 << N_IN;

    state_t           state_q, state_d;
    logic [CODES-1:0] exp_q, exp_d;
    logic [CODES-1:0] cap_q, cap_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [N_IN-1:0]  first_q, first_d;
    logic [N_IN:0]    err_q, err_d;
    logic             pass_q, pass_d;
    logic             load, dec, zero;

    settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .dec_i  (dec),
        .zero_o (zero)
    );

    // idx doubles as the registered stimulus, so dut_in holds the last code after the sweep.
    assign bus.dut_in    = idx_q;
    assign bus.busy      = state_q != ST_IDLE;
    assign bus.done      = state_q == ST_FIN;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.first_err = first_q;
    assign bus.captured  = cap_q;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        cap_d   = cap_q;
        idx_d   = idx_q;
        first_d = first_q;
        err_d   = err_q;
        pass_d  = pass_q;
        load    = 1'b0;
        dec     = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                exp_d   = bus.expected;
                cap_d   = '0;
                idx_d   = '0;
                first_d = '0;
                err_d   = '0;
                pass_d  = 1'b0;
                load    = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                dec     = !zero;
                state_d = zero ? ST_SAMPLE : ST_WAIT;
            end
            ST_SAMPLE: begin
                cap_d[idx_q] = bus.dut_out;
                if (bus.dut_out != exp_q[idx_q]) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) first_d = idx_q;
                end
                if (&idx_q) begin
                    state_d = ST_FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    load    = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_FIN: begin
                pass_d  = err_q == '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            cap_q   <= '0;
            idx_q   <= '0;
            first_q <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: directed sweeps of three checker configurations against a behavioural model
module tb_truth_table_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stuck = 1'b0;
    logic [15:0] exp16 = '0;
    int          sel = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    truth_table_checker_if #(.N_IN(4)) ia ();
    truth_table_checker_if #(.N_IN(4)) ib ();
    truth_table_checker_if #(.N_IN(2)) ic ();

    truth_table_checker #(.N_IN(4), .SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    truth_table_checker #(.N_IN(4), .SETTLE(3)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    truth_table_checker #(.N_IN(2), .SETTLE(1)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

    // Device stand-ins: f = a&b | ~c&d (a = MSB), a 2-cycle registered copy of it, and XOR.
    function automatic logic f4(input logic [3:0] x);
        return (x[3] & x[2]) | (~x[1] & x[0]);
    endfunction

    logic r1, r2;
    always_ff @(posedge clk) begin
        r1 <= rst ? 1'b0 : f4(ib.dut_in);
        r2 <= rst ? 1'b0 : r1;
    end

    assign ia.start    = start && sel == 0;
    assign ib.start    = start && sel == 1;
    assign ic.start    = start && sel == 2;
    assign ia.expected = exp16;
    assign ib.expected = exp16;
    assign ic.expected = exp16[3:0];
    assign ia.dut_out  = stuck ? 1'b1 : f4(ia.dut_in);
    assign ib.dut_out  = r2;
    assign ic.dut_out  = ^ic.dut_in;

    logic [3:0]  o_din, o_first;
    logic [4:0]  o_err;
    logic [15:0] o_cap;
    logic        o_busy, o_done, o_pass;

    always_comb begin
        o_din   = sel == 0 ? ia.dut_in    : sel == 1 ? ib.dut_in    : {2'b0, ic.dut_in};
        o_first = sel == 0 ? ia.first_err : sel == 1 ? ib.first_err : {2'b0, ic.first_err};
        o_err   = sel == 0 ? ia.err_count : sel == 1 ? ib.err_count : {2'b0, ic.err_count};
        o_cap   = sel == 0 ? ia.captured  : sel == 1 ? ib.captured  : {12'b0, ic.captured};
        o_busy  = sel == 0 ? ia.busy      : sel == 1 ? ib.busy      : ic.busy;
        o_done  = sel == 0 ? ia.done      : sel == 1 ? ib.done      : ic.done;
        o_pass  = sel == 0 ? ia.pass      : sel == 1 ? ib.pass      : ic.pass;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, act, req);
        end
    endtask

    // Model of what the sampled function must produce for each code.
    function automatic bit model_f(input int k, input bit stk, input int code);
        bit a, b, c, d;
        if (stk) return 1'b1;
        if (k == 2) return ((code >> 1) & 1) != (code & 1);
        a = ((code >> 3) & 1) != 0;
        b = ((code >> 2) & 1) != 0;
        c = ((code >> 1) & 1) != 0;
        d = (code & 1) != 0;
        return (a && b) || (!c && d);
    endfunction

    // One full sweep, checked every cycle from the start edge until one cycle past done.
    task automatic run(input int k, input logic [15:0] ex, input bit stk, input int n,
                       input int s, input bit poke, output int lat);
        int          codes = 1 << n;
        int          lat_m = codes * (s + 1) + 1;
        logic [15:0] m_cap = '0;
        int          m_err = 0;
        int          m_first = 0;
        int          din_m;
        for (int i = 0; i < codes; i++) begin
            m_cap[i] = model_f(k, stk, i);
            if (m_cap[i] != ex[i]) begin
                if (m_err == 0) m_first = i;
                m_err++;
            end
        end
        lat = 0;
        @(negedge clk);
        sel = k; exp16 = ex; stuck = stk; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= lat_m + 1; c++) begin
            if (poke && c == 5) begin start = 1'b1; exp16 = ~ex; end
            if (poke && c == 6) start = 1'b0;
            if (c == 1) begin
                chk($sformatf("cleared_err sel%0d", k), 32'(o_err), 0);
                chk($sformatf("cleared_cap sel%0d", k), 32'(o_cap), 0);
                chk($sformatf("cleared_pass sel%0d", k), 32'(o_pass), 0);
            end
            din_m = (c - 1) / (s + 1);
            if (din_m > codes - 1) din_m = codes - 1;
            chk($sformatf("dut_in sel%0d c%0d", k, c), 32'(o_din), 32'(din_m));
            chk($sformatf("busy sel%0d c%0d", k, c), 32'(o_busy), 32'(c <= lat_m));
            chk($sformatf("done sel%0d c%0d", k, c), 32'(o_done), 32'(c == lat_m));
            if (o_done && lat == 0) lat = c;
            if (c == lat_m + 1) begin
                chk($sformatf("captured sel%0d", k), 32'(o_cap), 32'(m_cap));
                chk($sformatf("err_count sel%0d", k), 32'(o_err), 32'(m_err));
                chk($sformatf("first_err sel%0d", k), 32'(o_first), 32'(m_first));
                chk($sformatf("pass sel%0d", k), 32'(o_pass), 32'(m_err == 0));
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic zero_outputs(input string nm);
        chk({nm, " dut_in"}, 32'(o_din), 0);
        chk({nm, " busy"}, 32'(o_busy), 0);
        chk({nm, " done"}, 32'(o_done), 0);
        chk({nm, " pass"}, 32'(o_pass), 0);
        chk({nm, " err_count"}, 32'(o_err), 0);
        chk({nm, " first_err"}, 32'(o_first), 0);
        chk({nm, " captured"}, 32'(o_cap), 0);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1 zero_outputs($sformatf("reset sel%0d", k));
        end
        rst = 1'b0;

        // Known-good function, with a start and an expected change injected mid-sweep.
        run(0, 16'hF222, 1'b0, 4, 1, 1'b1, lat);
        chk("lat_a", 32'(lat), 33);
        chk("cap_a_lit", 32'(o_cap), 32'h0000_F222);
        chk("pass_a_lit", 32'(o_pass), 1);

        run(0, 16'hF223, 1'b0, 4, 1, 1'b0, lat);
        chk("err_one_lit", 32'(o_err), 1);
        chk("first_one_lit", 32'(o_first), 0);
        chk("pass_one_lit", 32'(o_pass), 0);

        run(0, 16'h0000, 1'b1, 4, 1, 1'b0, lat);
        chk("err_stuck_lit", 32'(o_err), 16);
        chk("first_stuck_lit", 32'(o_first), 0);
        stuck = 1'b0;

        run(1, 16'hF222, 1'b0, 4, 3, 1'b0, lat);
        chk("lat_b", 32'(lat), 65);
        chk("pass_b_lit", 32'(o_pass), 1);

        // Reset partway through a failing sweep, with start held alongside it.
        @(negedge clk);
        sel = 0; exp16 = 16'hF223; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_err_before_rst", 32'(o_err), 1);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        zero_outputs("mid_rst");
        rst = 1'b0; start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk($sformatf("no_done_after_rst c%0d", c), 32'(o_done), 0);
        end

        run(0, 16'hF222, 1'b0, 4, 1, 1'b0, lat);
        chk("lat_after_rst", 32'(lat), 33);

        run(2, 16'h0007, 1'b0, 2, 1, 1'b0, lat);
        chk("err_c_wrong_lit", 32'(o_err), 1);
        run(2, 16'h0006, 1'b0, 2, 1, 1'b0, lat);
        chk("lat_c", 32'(lat), 9);
        chk("pass_c_lit", 32'(o_pass), 1);
        chk("cap_c_lit", 32'(o_cap), 32'h6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
